attention_av: RTL and testbench

ATTENTION_AV -- requirements
Module: attention_av

---
 rtl/attention_av_if.sv | 18 +
 rtl/attention_av.sv | 127 ++++++++++++
 tb/tb_attention_av.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/attention_av_if.sv
// Handshake and data bundle for attention_av: start request, score/value inputs,
// result matrix and completion pulses.
interface attention_av_if #(
   parameter int DATA_WIDTH = 16,
   parameter int L = 8,
   parameter int N = 1,
   parameter int E = 8
);
   logic                         start;
   logic [DATA_WIDTH*L*N*L-1:0]  A_in;
   logic [DATA_WIDTH*L*N*E-1:0]  V_in;
   logic [DATA_WIDTH*L*N*E-1:0]  Z_out;
   logic                         done;
   logic                         out_valid;

   modport master (output start, A_in, V_in, input Z_out, done, out_valid);
   modport slave  (input start, A_in, V_in, output Z_out, done, out_valid);
endinterface

// File: rtl/attention_av.sv
// Z = A x V per batch/head lane, one MAC per cycle per lane, sequenced by an
// IDLE/LOAD/COMPUTE/DONE controller with wrapping 2*DATA_WIDTH accumulation.
module attention_av #(
   parameter int DATA_WIDTH = 16,
   parameter int L = 8,
   parameter int N = 1,
   parameter int E = 8
) (
   input logic           clk,
   input logic           rst_n,
   attention_av_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = DW*L*N*L;
   localparam int VW = DW*L*N*E;
   localparam int LW = (L > 1) ? $clog2(L) : 1;
   localparam int EW = (E > 1) ? $clog2(E) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
   state_t state, state_next;

   logic [LW-1:0] l_cnt, j_cnt;
   logic [EW-1:0] e_cnt;
   logic [AW-1:0] a_reg;
   logic [VW-1:0] v_reg, z_work;

   logic signed [2*DW-1:0] acc   [N];
   logic signed [2*DW-1:0] a_el  [N];
   logic signed [2*DW-1:0] v_el  [N];
   logic signed [2*DW-1:0] prod  [N];
   logic signed [2*DW-1:0] sum   [N];
   int                     a_idx [N];
   int                     v_idx [N];
   int                     z_idx [N];

   logic j_last, e_last, l_last, last_mac;

   assign j_last   = (j_cnt == LW'(L-1));
   assign e_last   = (e_cnt == EW'(E-1));
   assign l_last   = (l_cnt == LW'(L-1));
   assign last_mac = (state == COMPUTE) && j_last && e_last && l_last;

   // Element addressing follows the reversed-row / reversed-column packing of the flat buses.
   always_comb begin
      for (int unsigned n = 0; n < N; n++) begin
         a_idx[n] = (L-1-int'(l_cnt))*N*L + int'(n)*L + (L-1-int'(j_cnt));
         v_idx[n] = int'(j_cnt)*N*E + int'(n)*E + (E-1-int'(e_cnt));
         z_idx[n] = (L-1-int'(l_cnt))*N*E + int'(n)*E + (E-1-int'(e_cnt));
         a_el[n]  = {{DW{a_reg[a_idx[n]*DW+DW-1]}}, a_reg[a_idx[n]*DW +: DW]};
         v_el[n]  = {{DW{v_reg[v_idx[n]*DW+DW-1]}}, v_reg[v_idx[n]*DW +: DW]};
         prod[n]  = a_el[n] * v_el[n];
         sum[n]   = acc[n] + prod[n];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = bus.start ? LOAD : IDLE;
         LOAD:    state_next = COMPUTE;
         COMPUTE: state_next = last_mac ? DONE : COMPUTE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         l_cnt         <= '0;
         e_cnt         <= '0;
         j_cnt         <= '0;
         a_reg         <= '0;
         v_reg         <= '0;
         z_work        <= '0;
         bus.Z_out     <= '0;
         bus.done      <= 1'b0;
         bus.out_valid <= 1'b0;
         for (int unsigned n = 0; n < N; n++) acc[n] <= '0;
      end else begin
         bus.done      <= 1'b0;
         bus.out_valid <= 1'b0;
         case (state)
            LOAD: begin
               a_reg <= bus.A_in;
               v_reg <= bus.V_in;
               l_cnt <= '0;
               e_cnt <= '0;
               j_cnt <= '0;
               for (int unsigned n = 0; n < N; n++) acc[n] <= '0;
            end
            COMPUTE: begin
               // Final j folds the current product straight into Z, freeing the accumulator.
               for (int unsigned n = 0; n < N; n++) begin
                  if (j_last) begin
                     z_work[z_idx[n]*DW +: DW] <= sum[n][DW-1:0];
                     acc[n] <= '0;
                  end else begin
                     acc[n] <= sum[n];
                  end
               end
               if (j_last) begin
                  j_cnt <= '0;
                  if (e_last) begin
                     e_cnt <= '0;
                     l_cnt <= l_last ? '0 : l_cnt + LW'(1);
                  end else begin
                     e_cnt <= e_cnt + EW'(1);
                  end
               end else begin
                  j_cnt <= j_cnt + LW'(1);
               end
            end
            DONE: begin
               bus.Z_out     <= z_work;
               bus.done      <= 1'b1;
               bus.out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_attention_av.sv
// Self-checking bench: directed 2x2 vectors, reset/restart and back-to-back corner
// cases, and randomized checks against a plain-arithmetic matrix product model.
module tb_attention_av;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   always #5 clk = ~clk;

   attention_av_if #(.DATA_WIDTH(16), .L(2), .N(1), .E(2)) bs ();
   attention_av_if #(.DATA_WIDTH(16), .L(8), .N(1), .E(8)) bb ();

   attention_av #(.DATA_WIDTH(16), .L(2), .N(1), .E(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
   attention_av #(.DATA_WIDTH(16), .L(8), .N(1), .E(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

   typedef struct {
      int a [4];
      int v [4];
      int z [4];
   } vec_t;
   vec_t tbl [4];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, got, exp);
   endtask

   // Row-major m[r*2+c] into the flat 2x2 packings.
   function automatic logic [63:0] pack_a(input int m [4]);
      logic [63:0] r = '0;
      for (int l = 0; l < 2; l++)
         for (int j = 0; j < 2; j++) r[((1-l)*2 + (1-j))*16 +: 16] = 16'(m[l*2+j]);
      return r;
   endfunction

   function automatic logic [63:0] pack_v(input int m [4]);
      logic [63:0] r = '0;
      for (int j = 0; j < 2; j++)
         for (int e = 0; e < 2; e++) r[(j*2 + (1-e))*16 +: 16] = 16'(m[j*2+e]);
      return r;
   endfunction

   function automatic logic [63:0] pack_z(input int m [4]);
      logic [63:0] r = '0;
      for (int l = 0; l < 2; l++)
         for (int e = 0; e < 2; e++) r[((1-l)*2 + (1-e))*16 +: 16] = 16'(m[l*2+e]);
      return r;
   endfunction

   // Exact integer matrix product, truncated to 16 bits at the end.
   function automatic logic [1023:0] model(input logic [1023:0] a, input logic [1023:0] v,
                                           input int ll, input int nn, input int ee);
      logic [1023:0] z = '0;
      longint s;
      logic signed [15:0] x, y;
      for (int l = 0; l < ll; l++)
         for (int n = 0; n < nn; n++)
            for (int e = 0; e < ee; e++) begin
               s = 0;
               for (int j = 0; j < ll; j++) begin
                  x = a[((ll-1-l)*nn*ll + n*ll + (ll-1-j))*16 +: 16];
                  y = v[(j*nn*ee + n*ee + (ee-1-e))*16 +: 16];
                  s += longint'(x) * longint'(y);
               end
               z[((ll-1-l)*nn*ee + n*ee + (ee-1-e))*16 +: 16] = s[15:0];
            end
      return z;
   endfunction

   // Start is raised just after edge T; lat counts edges from T until done is seen.
   task automatic run_s(input logic [63:0] a, input logic [63:0] v, output int lat);
      @(posedge clk); #1;
      bs.A_in = a; bs.V_in = v; bs.start = 1'b1;
      @(posedge clk); #1;
      bs.start = 1'b0;
      lat = 1;
      while (!bs.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bs.done) lat = -1;
   endtask

   task automatic run_b(input logic [1023:0] a, input logic [1023:0] v, output int lat);
      @(posedge clk); #1;
      bb.A_in = a; bb.V_in = v; bb.start = 1'b1;
      @(posedge clk); #1;
      bb.start = 1'b0;
      lat = 1;
      while (!bb.done && lat < 600) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bb.done) lat = -1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, pulses, t0;
      int dt [3];
      logic [63:0] a64, v64, zcap;
      logic [1023:0] abig, vbig, zexp;

      tbl[0].a = '{1, 0, 0, 1};   tbl[0].v = '{3, -4, 5, 6}; tbl[0].z = '{3, -4, 5, 6};
      tbl[1].a = '{2, 2, 2, 2};   tbl[1].v = '{1, 2, 3, 4};  tbl[1].z = '{8, 12, 8, 12};
      tbl[2].a = '{-1, 2, 0, -3}; tbl[2].v = '{1, 2, 3, 4};  tbl[2].z = '{5, 6, -9, -12};
      tbl[3].a = '{256, 0, 0, 0}; tbl[3].v = '{256, 1, 0, 0}; tbl[3].z = '{0, 256, 0, 0};

      bs.start = 1'b0; bs.A_in = '0; bs.V_in = '0;
      bb.start = 1'b0; bb.A_in = '0; bb.V_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_z", bs.Z_out, 64'd0);
      chk("reset_done", 64'(bs.done), 64'd0);
      chk("reset_valid", 64'(bs.out_valid), 64'd0);
      chk("reset_big_done", 64'(bb.done), 64'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_s(pack_a(tbl[i].a), pack_v(tbl[i].v), lat);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd11);
         chk($sformatf("vec%0d_z", i), bs.Z_out, pack_z(tbl[i].z));
         chk($sformatf("vec%0d_valid", i), 64'(bs.out_valid), 64'd1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pulse_end", i), 64'({bs.done, bs.out_valid}), 64'd0);
      end

      // Reset during COMPUTE aborts the run and clears the result.
      @(posedge clk); #1;
      bs.A_in = pack_a(tbl[1].a); bs.V_in = pack_v(tbl[1].v); bs.start = 1'b1;
      @(posedge clk); #1;
      bs.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_z", bs.Z_out, 64'd0);
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bs.done) pulses++;
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      chk("abort_z_hold", bs.Z_out, 64'd0);
      run_s(pack_a(tbl[2].a), pack_v(tbl[2].v), lat);
      chk("restart_lat", 64'(lat), 64'd11);
      chk("restart_z", bs.Z_out, pack_z(tbl[2].z));

      // Inputs changed and start re-pulsed after capture must not disturb the run.
      @(posedge clk); #1;
      bs.A_in = pack_a(tbl[1].a); bs.V_in = pack_v(tbl[1].v); bs.start = 1'b1;
      @(posedge clk); #1;
      bs.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bs.A_in = {$urandom, $urandom}; bs.V_in = {$urandom, $urandom}; bs.start = 1'b1;
      @(posedge clk); #1;
      bs.start = 1'b0;
      pulses = 0; zcap = '0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bs.done) begin pulses++; zcap = bs.Z_out; end
      end
      chk("ignore_start_pulses", 64'(pulses), 64'd1);
      chk("captured_z", zcap, pack_z(tbl[1].z));

      // Start held high: back-to-back runs.
      @(posedge clk); #1;
      bs.A_in = pack_a(tbl[0].a); bs.V_in = pack_v(tbl[0].v); bs.start = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bs.done) begin
            if (pulses < 3) dt[pulses] = k;
            pulses++;
         end
      end
      bs.start = 1'b0;
      chk("b2b_count", 64'(pulses), 64'd3);
      chk("b2b_first", 64'(dt[0]), 64'd11);
      chk("b2b_second", 64'(dt[1]), 64'd22);
      chk("b2b_third", 64'(dt[2]), 64'd33);
      chk("b2b_z", bs.Z_out, pack_z(tbl[0].z));
      repeat (20) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         a64 = {$urandom, $urandom};
         v64 = {$urandom, $urandom};
         run_s(a64, v64, lat);
         zexp = model({960'd0, a64}, {960'd0, v64}, 2, 1, 2);
         chk($sformatf("rand%0d_lat", i), 64'(lat), 64'd11);
         chk($sformatf("rand%0d_z", i), bs.Z_out, zexp[63:0]);
      end

      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 32; w++) begin
            abig[w*32 +: 32] = $urandom;
            vbig[w*32 +: 32] = $urandom;
         end
         run_b(abig, vbig, lat);
         zexp = model(abig, vbig, 8, 1, 8);
         chk($sformatf("big%0d_lat", i), 64'(lat), 64'd515);
         for (int w = 0; w < 16; w++)
            chk($sformatf("big%0d_z%0d", i, w), bb.Z_out[w*64 +: 64], zexp[w*64 +: 64]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
